dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, a free-running timer with compare
// interrupt, and a byte-wide TX FIFO, all behind one CPU load/store port.
module dmem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0] TIMER_WA  = 30'h3FFF_C000;
    localparam logic [29:0] CMP_WA    = 30'h3FFF_C001;
    localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;
    localparam logic [29:0] TXDATA_WA = 30'h3FFF_C003;

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [31:0] timer;
    logic [31:0] cmp;
    logic        irq_flag;
    logic        overflow;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          ram_sel;
    logic          timer_sel, cmp_sel, status_sel, txdata_sel;
    logic          full, empty;
    logic          push, pop, push_ok, push_drop;
    logic          irq_set;
    logic [2:0]    status_cnt;
    logic [31:0]   status_word;
    logic [1:0]    addr_unused;

    // Byte offset within a word never affects decode.
    assign addr_unused = memaddr[1:0];

    assign word_addr  = memaddr[31:2];
    assign ram_idx    = memaddr[AW+1:2];
    assign ram_sel    = (memaddr[31:AW+2] == '0);
    assign timer_sel  = (word_addr == TIMER_WA);
    assign cmp_sel    = (word_addr == CMP_WA);
    assign status_sel = (word_addr == STATUS_WA);
    assign txdata_sel = (word_addr == TXDATA_WA);

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));

    assign push      = memwrite & txdata_sel;
    assign pop       = tx_valid & tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    assign irq_set = (timer == cmp);

    assign tx_valid = ~empty;
    // Masked so the output is zero after reset without clearing the storage.
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign irq      = irq_flag;

    assign status_cnt  = 3'(count);
    assign status_word = {25'd0, status_cnt, overflow, empty, full, irq_flag};

    // Timer, compare register and sticky interrupt/overflow flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer    <= 32'd0;
            cmp      <= 32'hFFFF_FFFF;
            irq_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (memwrite && timer_sel) timer <= memwritedata;
            else                       timer <= timer + 32'd1;

            if (memwrite && cmp_sel) cmp <= memwritedata;

            if (irq_set)                                         irq_flag <= 1'b1;
            else if (memwrite && status_sel && memwritedata[0]) irq_flag <= 1'b0;

            if (push_drop)                                       overflow <= 1'b1;
            else if (memwrite && status_sel && memwritedata[3]) overflow <= 1'b0;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; when full with a pop, the new byte lands in the freed head slot.
    always_ff @(posedge clk) begin
        if (reset && push_ok) fifo_mem[wr_ptr] <= memwritedata[7:0];
    end

    // Data RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && memwrite && ram_sel) ram[ram_idx] <= memwritedata;
    end

    // Zero-latency read mux; unmapped and TXDATA read as zero.
    always_comb begin
        memreaddata = 32'd0;
        if (ram_sel)         memreaddata = ram[ram_idx];
        else if (timer_sel)  memreaddata = timer;
        else if (cmp_sel)    memreaddata = cmp;
        else if (status_sel) memreaddata = status_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, timer/irq, TX FIFO, reset, unmapped.
module tb_dmem_responder;

    localparam logic [31:0] A_TIMER  = 32'hFFFF_0000;
    localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        memaddr      = addr;
        memwritedata = data;
        memwrite     = 1'b1;
        tick();
        memwrite     = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        memaddr = addr;
        #1;
        check(memreaddata, exp, tag);
    endtask

    initial begin
        reset        = 1'b0;
        memwrite     = 1'b0;
        memaddr      = 32'd0;
        memwritedata = 32'd0;
        tx_ready     = 1'b0;
        tick();
        tick();

        // Reset state.
        check({31'd0, tx_valid}, 32'd0, "rst_tx_valid");
        check({24'd0, tx_data}, 32'd0, "rst_tx_data");
        check({31'd0, irq}, 32'd0, "rst_irq");
        read_check(A_STATUS, 32'h04, "rst_status");
        read_check(A_TIMER, 32'd0, "rst_timer");
        read_check(A_CMP, 32'hFFFF_FFFF, "rst_cmp");
        reset = 1'b1;

        // RAM write/read, byte offset ignored, last word.
        write_word(32'h0000_0010, 32'h1234_5678);
        read_check(32'h0000_0010, 32'h1234_5678, "ram_rd_10");
        read_check(32'h0000_0012, 32'h1234_5678, "ram_rd_12");
        write_word(32'h0000_00FC, 32'hCAFE_F00D);
        read_check(32'h0000_00FC, 32'hCAFE_F00D, "ram_last_word");
        write_word(32'h0000_0000, 32'h0000_0000);

        // Unmapped accesses.
        write_word(32'h8000_0000, 32'h5555_5555);
        read_check(32'h8000_0000, 32'd0, "unmapped_rd");
        read_check(32'h0000_0000, 32'd0, "unmapped_no_ram0");
        read_check(A_CMP, 32'hFFFF_FFFF, "unmapped_no_cmp");
        write_word(32'h0000_0100, 32'h0000_DEAD);
        read_check(32'h0000_0100, 32'd0, "past_ram_rd");
        read_check(32'h0000_0000, 32'd0, "past_ram_no_alias");
        read_check(32'h0000_0010, 32'h1234_5678, "ram_10_kept");

        // Timer load and compare interrupt.
        write_word(A_TIMER, 32'h0000_1000);
        write_word(A_CMP, 32'h0000_0010);
        write_word(A_TIMER, 32'h0000_000C);
        read_check(A_TIMER, 32'h0000_000C, "timer_load");
        for (int i = 0; i < 4; i++) begin
            check({31'd0, irq}, 32'd0, "irq_not_yet");
            tick();
        end
        check({31'd0, irq}, 32'd0, "irq_edge4");
        tick();
        check({31'd0, irq}, 32'd1, "irq_edge5");
        read_check(A_STATUS, 32'h05, "status_irq");
        write_word(A_STATUS, 32'h0000_0001);
        check({31'd0, irq}, 32'd0, "irq_cleared");
        write_word(A_TIMER, 32'hFFFF_FFFF);
        read_check(A_TIMER, 32'hFFFF_FFFF, "timer_max");
        tick();
        read_check(A_TIMER, 32'd0, "timer_wrap");

        // Set beats clear in the same cycle.
        write_word(A_TIMER, 32'h0000_0010);
        write_word(A_STATUS, 32'h0000_0001);
        check({31'd0, irq}, 32'd1, "irq_set_wins");
        write_word(A_STATUS, 32'h0000_0001);
        check({31'd0, irq}, 32'd0, "irq_clear2");

        // FIFO fill and overflow.
        write_word(A_TXDATA, 32'h0000_00A1);
        check({31'd0, tx_valid}, 32'd1, "push_empty_valid");
        check({24'd0, tx_data}, 32'hA1, "push_empty_data");
        write_word(A_TXDATA, 32'h0000_00A2);
        write_word(A_TXDATA, 32'h0000_00A3);
        write_word(A_TXDATA, 32'h0000_00A4);
        read_check(A_STATUS, 32'h42, "status_full");
        write_word(A_TXDATA, 32'h0000_00A5);
        read_check(A_STATUS, 32'h4A, "status_overflow");
        read_check(A_TXDATA, 32'd0, "txdata_rd_zero");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({31'd0, tx_valid}, 32'd1, "drain_valid");
            check({24'd0, tx_data}, 32'hA1 + 32'(i), "drain_data");
            tick();
        end
        check({31'd0, tx_valid}, 32'd0, "drained_valid");
        tick();
        read_check(A_STATUS, 32'h0C, "status_empty_ovf");
        write_word(A_STATUS, 32'h0000_0008);
        read_check(A_STATUS, 32'h04, "ovf_cleared");

        // Full FIFO with push and pop in the same cycle.
        tx_ready = 1'b0;
        write_word(A_TXDATA, 32'h0000_00C1);
        write_word(A_TXDATA, 32'h0000_00C2);
        write_word(A_TXDATA, 32'h0000_00C3);
        write_word(A_TXDATA, 32'h0000_00C4);
        tx_ready = 1'b1;
        write_word(A_TXDATA, 32'h0000_00B0);
        tx_ready = 1'b0;
        read_check(A_STATUS, 32'h42, "full_pop_push_status");
        tx_ready = 1'b1;
        check({24'd0, tx_data}, 32'hC2, "fp_data0");
        tick();
        check({24'd0, tx_data}, 32'hC3, "fp_data1");
        tick();
        check({24'd0, tx_data}, 32'hC4, "fp_data2");
        tick();
        check({24'd0, tx_data}, 32'hB0, "fp_data3");
        tick();
        check({31'd0, tx_valid}, 32'd0, "fp_empty");
        tx_ready = 1'b0;

        // Reset mid-operation.
        write_word(A_TXDATA, 32'h0000_00D1);
        write_word(A_TXDATA, 32'h0000_00D2);
        write_word(A_TXDATA, 32'h0000_00D3);
        write_word(A_TIMER, 32'h0000_0010);
        tick();
        read_check(A_STATUS, 32'h31, "pre_reset_status");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check({31'd0, tx_valid}, 32'd0, "mid_rst_valid");
        check({24'd0, tx_data}, 32'd0, "mid_rst_data");
        read_check(A_STATUS, 32'h04, "mid_rst_status");
        read_check(A_TIMER, 32'd0, "mid_rst_timer");
        read_check(A_CMP, 32'hFFFF_FFFF, "mid_rst_cmp");
        read_check(32'h0000_0010, 32'h1234_5678, "mid_rst_ram");
        tick();
        read_check(A_TIMER, 32'd1, "timer_first_inc");
        write_word(A_TXDATA, 32'h0000_00E1);
        check({24'd0, tx_data}, 32'hE1, "post_rst_push");
        read_check(A_STATUS, 32'h10, "post_rst_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
